// File: rtl/cpld_spi_responder_if.sv
// cpld_spi_responder_if: DSP SPI pins plus the CPLD register read/write bus
interface cpld_spi_responder_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  spi_clk;
  logic                  spi_mosi;
  logic                  spi_cs_INV;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_err;
  logic                  busy;
  modport slave (
    input  spi_clk, spi_mosi, spi_cs_INV, rd_data,
    output spi_miso, spi_miso_oe, rd_addr, rd_req, wr_en, wr_addr, wr_data, frame_err, busy
  );
  modport master (
    output spi_clk, spi_mosi, spi_cs_INV, rd_data,
    input  spi_miso, spi_miso_oe, rd_addr, rd_req, wr_en, wr_addr, wr_data, frame_err, busy
  );
endinterface

// File: rtl/cpld_spi_responder.sv
// cpld_spi_responder: oversampled SPI mode-0 slave decoding {R/nW,addr},data frames into register strobes
module cpld_spi_responder #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input logic                 sysclk,
  input logic                 reset_INV,
  cpld_spi_responder_if.slave bus
);
  localparam int FL = 8 + DATA_WIDTH;
  localparam int CW = $clog2(FL + 1);
  localparam int SW = DATA_WIDTH > 8 ? DATA_WIDTH : 8;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t                state, state_nx;
  logic [2:0]            sclk_s, cs_s;
  logic [1:0]            mosi_s;
  logic [CW-1:0]         cnt;
  logic [SW-2:0]         rx;
  logic [SW-1:0]         rx_nx;
  logic [DATA_WIDTH-1:0] tx;
  logic                  rnw;
  logic                  rise, fall, cs_rise, cs_fall;
  logic                  active, start, cmd_end, last, abort, rd_shift;
  assign rise     = sclk_s[1] & ~sclk_s[2];
  assign fall     = ~sclk_s[1] & sclk_s[2];
  assign cs_rise  = cs_s[1] & ~cs_s[2];
  assign cs_fall  = ~cs_s[1] & cs_s[2];
  assign active   = state == CMD || state == DATA;
  assign start    = state == IDLE && cs_fall;
  assign rx_nx    = {rx, mosi_s[1]};
  assign cmd_end  = state == CMD && rise && cnt == CW'(7);
  assign last     = state == DATA && rise && cnt == CW'(FL - 1);
  // the final edge wins over a simultaneous CS rise, so a complete frame is never an error
  assign abort    = active && cs_rise && !last;
  assign rd_shift = state == DATA && rnw && fall;
  assign bus.busy        = state != IDLE;
  assign bus.spi_miso_oe = state != IDLE;
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      sclk_s <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], bus.spi_clk};
      cs_s   <= {cs_s[1:0], bus.spi_cs_INV};
      mosi_s <= {mosi_s[0], bus.spi_mosi};
    end
  end
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) state <= IDLE;
    else            state <= state_nx;
  end
  always_comb begin
    state_nx = cs_rise ? IDLE : start ? CMD : cmd_end ? DATA : last ? DONE : state;
  end
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      cnt           <= '0;
      rx            <= '0;
      tx            <= '0;
      rnw           <= 1'b0;
      bus.rd_addr   <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.rd_req    <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.spi_miso  <= 1'b0;
    end else begin
      cnt           <= start ? '0 : (active && rise && cnt != CW'(FL)) ? cnt + CW'(1) : cnt;
      rx            <= start ? '0 : (active && rise) ? rx_nx[SW-2:0] : rx;
      rnw           <= cmd_end ? rx_nx[7] : rnw;
      bus.rd_addr   <= cmd_end ? ADDR_WIDTH'(rx_nx[6:0]) : bus.rd_addr;
      bus.wr_addr   <= cmd_end ? ADDR_WIDTH'(rx_nx[6:0]) : bus.wr_addr;
      bus.wr_data   <= (last && !rnw) ? rx_nx[DATA_WIDTH-1:0] : bus.wr_data;
      bus.rd_req    <= cmd_end && rx_nx[7];
      bus.wr_en     <= last && !rnw;
      bus.frame_err <= abort;
      // first falling edge of the data byte (no data bit counted yet) loads the read word
      tx            <= !rd_shift ? tx : (cnt == CW'(8)) ? {bus.rd_data[DATA_WIDTH-2:0], 1'b0} : {tx[DATA_WIDTH-2:0], 1'b0};
      bus.spi_miso  <= (state != DATA || !rnw || cs_rise) ? 1'b0 :
                       !fall ? bus.spi_miso :
                       (cnt == CW'(8)) ? bus.rd_data[DATA_WIDTH-1] : tx[DATA_WIDTH-1];
    end
  end
endmodule

// File: tb/tb_cpld_spi_responder.sv
// tb_cpld_spi_responder: directed frame table plus reset, back-to-back and CS-on-last-edge sequences
module tb_cpld_spi_responder;
  localparam int AW = 7;
  localparam int DW = 8;
  logic sysclk    = 1'b0;
  logic reset_INV = 1'b0;
  cpld_spi_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  cpld_spi_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sysclk(sysclk),
    .reset_INV(reset_INV),
    .bus(bus.slave)
  );
  always #5 sysclk = ~sysclk;
  int errors = 0;
  int checks = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_miso = 0;
  logic [AW-1:0] wa_log [64];
  logic [DW-1:0] wd_log [64];
  always @(negedge sysclk) begin
    if (reset_INV) begin
      if (bus.wr_en) begin
        wa_log[n_wr % 64] = bus.wr_addr;
        wd_log[n_wr % 64] = bus.wr_data;
        n_wr++;
      end
      if (bus.rd_req) n_rd++;
      if (bus.frame_err) n_err++;
      if (bus.spi_miso) n_miso++;
    end
  end
  typedef struct {
    string       name;
    logic [23:0] bits;
    int          nbits;
    logic [7:0]  rdd;
    int          exp_wr;
    logic [6:0]  exp_wa;
    logic [7:0]  exp_wd;
    int          exp_rd;
    logic [6:0]  exp_ra;
    logic [7:0]  exp_rx;
    int          exp_err;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic shift_bit(input logic b, output logic m, input bit cs_with_edge);
    bus.spi_mosi = b;
    repeat (4) @(negedge sysclk);
    m = bus.spi_miso;
    bus.spi_clk = 1'b1;
    if (cs_with_edge) bus.spi_cs_INV = 1'b1;
    repeat (4) @(negedge sysclk);
    bus.spi_clk = 1'b0;
  endtask
  task automatic frame(input logic [23:0] bits, input int nbits, output logic [23:0] rx, input bit cs_on_last);
    logic m;
    rx = '0;
    @(negedge sysclk);
    bus.spi_cs_INV = 1'b0;
    repeat (4) @(negedge sysclk);
    chk("miso_oe_in_frame", {31'b0, bus.spi_miso_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      shift_bit(bits[23-i], m, cs_on_last && i == nbits - 1);
      rx[23-i] = m;
    end
    repeat (4) @(negedge sysclk);
    bus.spi_cs_INV = 1'b1;
    repeat (5) @(negedge sysclk);
    chk("busy_after_cs", {31'b0, bus.busy}, 32'd0);
    chk("miso_oe_after_cs", {31'b0, bus.spi_miso_oe}, 32'd0);
    repeat (6) @(negedge sysclk);
  endtask
  initial begin
    int b_wr, b_rd, b_err, b_miso;
    logic [23:0] rx;
    logic m;
    vecs[0] = '{"write",     24'h05A500, 16, 8'h00, 1, 7'h05, 8'hA5, 0, 7'h00, 8'h00, 0};
    vecs[1] = '{"read",      24'h830000, 16, 8'h3C, 0, 7'h00, 8'h00, 1, 7'h03, 8'h3C, 0};
    vecs[2] = '{"short",     24'h10FF00, 12, 8'h00, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1};
    vecs[3] = '{"long",      24'h0255AA, 24, 8'h00, 1, 7'h02, 8'h55, 0, 7'h00, 8'h00, 0};
    vecs[4] = '{"read_7f",   24'hFF0000, 16, 8'h81, 0, 7'h00, 8'h00, 1, 7'h7F, 8'h81, 0};
    vecs[5] = '{"write_7f",  24'h7F0100, 16, 8'h00, 1, 7'h7F, 8'h01, 0, 7'h00, 8'h00, 0};
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_INV = 1'b1;
    bus.rd_data = '0;
    repeat (3) @(negedge sysclk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_oe", {31'b0, bus.spi_miso_oe}, 32'd0);
    chk("rst_miso", {31'b0, bus.spi_miso}, 32'd0);
    chk("rst_strobes", {29'b0, bus.wr_en, bus.rd_req, bus.frame_err}, 32'd0);
    chk("rst_addr", {18'b0, bus.rd_addr, bus.wr_addr}, 32'd0);
    chk("rst_wdata", {24'b0, bus.wr_data}, 32'd0);
    reset_INV = 1'b1;
    repeat (6) @(negedge sysclk);
    chk("spurious_cs_err", n_err, 0);
    foreach (vecs[k]) begin
      b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_miso = n_miso;
      bus.rd_data = vecs[k].rdd;
      frame(vecs[k].bits, vecs[k].nbits, rx, 1'b0);
      chk({vecs[k].name, "_wr_cnt"}, n_wr - b_wr, vecs[k].exp_wr);
      chk({vecs[k].name, "_rd_cnt"}, n_rd - b_rd, vecs[k].exp_rd);
      chk({vecs[k].name, "_err_cnt"}, n_err - b_err, vecs[k].exp_err);
      if (vecs[k].exp_wr == 1) begin
        chk({vecs[k].name, "_wr_addr"}, {25'b0, wa_log[b_wr % 64]}, {25'b0, vecs[k].exp_wa});
        chk({vecs[k].name, "_wr_data"}, {24'b0, wd_log[b_wr % 64]}, {24'b0, vecs[k].exp_wd});
      end
      if (vecs[k].exp_rd == 1) begin
        chk({vecs[k].name, "_rd_addr"}, {25'b0, bus.rd_addr}, {25'b0, vecs[k].exp_ra});
        chk({vecs[k].name, "_miso_byte"}, {24'b0, rx[15:8]}, {24'b0, vecs[k].exp_rx});
      end else begin
        chk({vecs[k].name, "_miso_quiet"}, n_miso - b_miso, 0);
      end
    end
    b_wr = n_wr; b_rd = n_rd; b_err = n_err;
    @(negedge sysclk);
    bus.spi_cs_INV = 1'b0;
    repeat (4) @(negedge sysclk);
    for (int i = 0; i < 6; i++) shift_bit(rx[0] ^ (i[0] == 1'b0), m, 1'b0);
    reset_INV = 1'b0;
    repeat (2) @(negedge sysclk);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_oe", {31'b0, bus.spi_miso_oe}, 32'd0);
    reset_INV = 1'b1;
    for (int i = 0; i < 10; i++) shift_bit(1'b1, m, 1'b0);
    chk("midrst_stay_idle", {31'b0, bus.busy}, 32'd0);
    repeat (4) @(negedge sysclk);
    bus.spi_cs_INV = 1'b1;
    repeat (10) @(negedge sysclk);
    chk("midrst_no_strobe", (n_wr - b_wr) + (n_rd - b_rd) + (n_err - b_err), 0);
    frame(24'h011100, 16, rx, 1'b0);
    chk("after_rst_wr_cnt", n_wr - b_wr, 1);
    chk("after_rst_wr", {17'b0, wa_log[b_wr % 64], wd_log[b_wr % 64]}, {17'b0, 7'h01, 8'h11});
    b_wr = n_wr; b_err = n_err;
    frame(24'h061200, 16, rx, 1'b0);
    frame(24'h073400, 16, rx, 1'b0);
    chk("b2b_wr_cnt", n_wr - b_wr, 2);
    chk("b2b_err_cnt", n_err - b_err, 0);
    chk("b2b_wr0", {17'b0, wa_log[b_wr % 64], wd_log[b_wr % 64]}, {17'b0, 7'h06, 8'h12});
    chk("b2b_wr1", {17'b0, wa_log[(b_wr + 1) % 64], wd_log[(b_wr + 1) % 64]}, {17'b0, 7'h07, 8'h34});
    b_wr = n_wr; b_err = n_err;
    frame(24'h095A00, 16, rx, 1'b1);
    chk("cs_last_wr_cnt", n_wr - b_wr, 1);
    chk("cs_last_err_cnt", n_err - b_err, 0);
    chk("cs_last_wr", {17'b0, wa_log[b_wr % 64], wd_log[b_wr % 64]}, {17'b0, 7'h09, 8'h5A});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
